imem_loader: RTL and testbench

//   Write-side counterpart of the fetch stage: fills instruction memory that fetch later reads.

---
 rtl/imem_loader.sv | 80 ++++++++
 tb/tb_imem_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a handshaked byte stream big-endian into words and writes them to instruction memory
module imem_loader #(
  parameter int WIDTH  = 32,
  parameter int DEPTHI = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DEPTHI-1:0] load_base,
  input  logic [DEPTHI-1:0] load_len,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              we,
  output logic [DEPTHI-1:0] waddr,
  output logic [WIDTH-1:0]  wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);
  localparam int BYTES = WIDTH / 8;
  localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
  state_t state, next;
  logic [CW-1:0] byte_cnt;
  logic [DEPTHI-1:0] addr, words_left;
  logic [WIDTH-1:0] shreg;
  logic hs, last_byte;
  assign byte_ready = state == S_COLLECT && !abort;
  assign we = state == S_WRITE && !abort;
  assign hs = byte_valid && byte_ready;
  assign last_byte = byte_cnt == CW'(BYTES - 1);
  assign waddr = addr;
  assign wdata = shreg;
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:    next = start ? (load_len == '0 ? S_DONE : S_COLLECT) : S_IDLE;
      S_COLLECT: next = hs && last_byte ? S_WRITE : S_COLLECT;
      S_WRITE:   next = words_left == DEPTHI'(1) ? S_DONE : S_COLLECT;
      default:   next = S_IDLE;
    endcase
    if (abort) next = S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      cpu_hold <= 1'b0;
      done <= 1'b0;
      wrapped <= 1'b0;
      byte_cnt <= '0;
      addr <= '0;
      words_left <= '0;
      shreg <= '0;
    end else begin
      state <= next;
      busy <= next != S_IDLE;
      cpu_hold <= next != S_IDLE;
      done <= next == S_DONE;
      if (next == S_COLLECT && state == S_IDLE) begin
        addr <= load_base;
        words_left <= load_len;
        wrapped <= 1'b0;
        byte_cnt <= '0;
      end
      if (hs) begin
        shreg <= {shreg[WIDTH-9:0], byte_in};
        byte_cnt <= last_byte ? '0 : byte_cnt + CW'(1);
      end
      if (we) begin
        addr <= addr + DEPTHI'(1);
        words_left <= words_left - DEPTHI'(1);
        if (&addr) wrapped <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads with a write scoreboard, plus abort, zero-length and async-reset sequences
module tb_imem_loader;
  logic clk = 0, rst = 1, start = 0, abort = 0, byte_valid = 0;
  logic [15:0] load_base = 0, load_len = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, we, cpu_hold, busy, done, wrapped;
  logic [15:0] waddr;
  logic [31:0] wdata;
  int checks = 0, errors = 0, done_cnt = 0, busy_cnt = 0;
  logic [47:0] exp_q[$];

  imem_loader dut (.clk(clk), .rst(rst), .start(start), .load_base(load_base), .load_len(load_len),
    .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready), .we(we),
    .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .wrapped(wrapped));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (we) begin
      if (exp_q.size() == 0) chk("unexpected_we", {waddr, wdata}, 48'h0);
      else chk("write", {waddr, wdata}, exp_q.pop_front());
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    load_base = b; load_len = l; start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t = 0;
    logic acc;
    byte_in = b; byte_valid = 1;
    do begin
      @(negedge clk); t++; acc = byte_ready;
      @(posedge clk); #1;
    end while (!acc && t < 50);
    if (!acc) chk("byte_timeout", 0, 1);
    byte_valid = 0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], gap);
  endtask

  task automatic wait_done(input logic exp_wrap);
    int t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 200);
    chk("done_seen", done, 1);
    chk("hold_in_done", cpu_hold, 1);
    @(negedge clk);
    chk("hold_after", {cpu_hold, busy, done}, 0);
    chk("wrapped", wrapped, exp_wrap);
    chk("all_written", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] base, len;
    bit gap;
    logic [31:0] w0, w1;
    logic wrap;
  } vec_t;
  vec_t vt[4];

  task automatic run(input vec_t v);
    logic [31:0] ws[2];
    int d0;
    ws[0] = v.w0; ws[1] = v.w1;
    d0 = done_cnt;
    for (int i = 0; i < v.len; i++) exp_q.push_back({16'(v.base + 16'(i)), ws[i]});
    do_start(v.base, v.len);
    @(negedge clk); chk("hold_rise", {cpu_hold, busy}, 2'b11);
    @(posedge clk); #1;
    for (int i = 0; i < v.len; i++) send_word(ws[i], v.gap);
    wait_done(v.wrap);
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    vt[0] = '{16'h0000, 16'd2, 0, 32'h20080005, 32'h8C090004, 0};
    vt[1] = '{16'h0000, 16'd2, 1, 32'h20080005, 32'h8C090004, 0};
    vt[2] = '{16'hFFFF, 16'd2, 0, 32'hDEADBEEF, 32'h12345678, 1};
    vt[3] = '{16'h1234, 16'd1, 1, 32'hA5A55A5A, 32'h0, 0};
    #12;
    chk("reset_outs", {byte_ready, we, waddr, wdata, cpu_hold, busy, done, wrapped}, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      run(vt[i]);
      if (i == 2) begin
        repeat (3) @(posedge clk);
        #1 chk("wrapped_sticky", wrapped, 1);
      end
    end
    d0 = done_cnt; busy_cnt = 0;
    do_start(16'h0033, 16'd0);
    repeat (5) @(posedge clk);
    #1 chk("len0_busy", busy_cnt, 1);
    chk("len0_done", done_cnt - d0, 1);
    d0 = done_cnt;
    do_start(16'h0010, 16'd3);
    send(8'h11, 0); send(8'h22, 0);
    abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort_idle", {busy, cpu_hold, byte_ready}, 0);
    repeat (6) @(posedge clk);
    #1 chk("abort_no_done", done_cnt - d0, 0);
    run('{16'h0020, 16'd1, 0, 32'hCAFEF00D, 32'h0, 0});
    do_start(16'h0042, 16'd2);
    send(8'h5A, 0); send(8'hC3, 0);
    #3 rst = 1;
    #1 chk("async_rst", {byte_ready, we, waddr, wdata, cpu_hold, busy, done, wrapped}, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("idle_after_rst", {busy, byte_ready, cpu_hold}, 0);
    chk("no_stray", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
